// File: rtl/sdram_arbiter_if.sv
// Requester and controller signals of the two-port SDRAM arbiter.
// slave is the arbiter's view; master is the requesters-plus-controller view.
interface sdram_arbiter_if #(
    parameter int SD_ADDR_WIDTH = 25,
    parameter int SD_DATA_WIDTH = 8
);
    logic [SD_ADDR_WIDTH-1:0] p0_addr;
    logic [SD_ADDR_WIDTH-1:0] p1_addr;
    logic [SD_DATA_WIDTH-1:0] p0_wr_data;
    logic [SD_DATA_WIDTH-1:0] p1_wr_data;
    logic                     p0_wr_enable;
    logic                     p1_wr_enable;
    logic                     p0_rd_enable;
    logic                     p1_rd_enable;
    logic                     p0_ack;
    logic                     p1_ack;
    logic [SD_DATA_WIDTH-1:0] p0_rd_data;
    logic [SD_DATA_WIDTH-1:0] p1_rd_data;
    logic                     p0_rd_ready;
    logic                     p1_rd_ready;
    logic                     p0_busy;
    logic                     p1_busy;

    logic [SD_ADDR_WIDTH-1:0] sd_addr;
    logic [SD_DATA_WIDTH-1:0] sd_wr_data;
    logic                     sd_wr_enable;
    logic                     sd_rd_enable;
    logic [SD_DATA_WIDTH-1:0] sd_rd_data;
    logic                     sd_rd_ready;
    logic                     sd_busy;
    logic                     sd_ack;

    modport slave (
        input  p0_addr, p1_addr, p0_wr_data, p1_wr_data,
               p0_wr_enable, p1_wr_enable, p0_rd_enable, p1_rd_enable,
               sd_rd_data, sd_rd_ready, sd_busy, sd_ack,
        output p0_ack, p1_ack, p0_rd_data, p1_rd_data,
               p0_rd_ready, p1_rd_ready, p0_busy, p1_busy,
               sd_addr, sd_wr_data, sd_wr_enable, sd_rd_enable
    );

    modport master (
        output p0_addr, p1_addr, p0_wr_data, p1_wr_data,
               p0_wr_enable, p1_wr_enable, p0_rd_enable, p1_rd_enable,
               sd_rd_data, sd_rd_ready, sd_busy, sd_ack,
        input  p0_ack, p1_ack, p0_rd_data, p1_rd_data,
               p0_rd_ready, p1_rd_ready, p0_busy, p1_busy,
               sd_addr, sd_wr_data, sd_wr_enable, sd_rd_enable
    );
endinterface

// File: rtl/sdram_arbiter.sv
// Two-port arbiter for one sdram_controller: one command in flight, ack/read data routed to the owner only.
// Grant 1 cycle after request, enables held until pN_ack; SDRAM_ARB_FIXED_PRIO_EN gives port 0 strict priority.
module sdram_arbiter #(
    parameter int SD_ADDR_WIDTH = 25,
    parameter int SD_DATA_WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    sdram_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, DRAIN} state_t;

    state_t                   state, state_nxt;
    logic                     owner, owner_nxt;
    logic                     is_rd, is_rd_nxt;
    logic                     last_grant, last_grant_nxt;
    logic [SD_ADDR_WIDTH-1:0] addr_q, addr_nxt;
    logic [SD_DATA_WIDTH-1:0] wdat_q, wdat_nxt;
    logic                     wr_en_q, wr_en_nxt;
    logic                     rd_en_q, rd_en_nxt;
    logic [1:0]               ack_q, ack_nxt;
    logic [1:0]               rdy_q, rdy_nxt;
    logic [1:0]               busy_q, busy_nxt;
    logic [SD_DATA_WIDTH-1:0] rdat0_q, rdat0_nxt;
    logic [SD_DATA_WIDTH-1:0] rdat1_q, rdat1_nxt;

    logic req0, req1, gnt, gnt_wr;

    assign req0 = bus.p0_wr_enable | bus.p0_rd_enable;
    assign req1 = bus.p1_wr_enable | bus.p1_rd_enable;

    always_comb begin : arbitration
`ifdef SDRAM_ARB_FIXED_PRIO_EN
        gnt = ~req0;
`else
        gnt = (req0 & req1) ? ~last_grant : req1;
`endif
        // A port raising both enables gets a write; its ack retires both.
        gnt_wr = gnt ? bus.p1_wr_enable : bus.p0_wr_enable;
    end

    always_comb begin : next_state
        state_nxt      = state;
        owner_nxt      = owner;
        is_rd_nxt      = is_rd;
        last_grant_nxt = last_grant;
        addr_nxt       = addr_q;
        wdat_nxt       = wdat_q;
        wr_en_nxt      = wr_en_q;
        rd_en_nxt      = rd_en_q;
        ack_nxt        = 2'b00;
        rdy_nxt        = 2'b00;
        busy_nxt       = busy_q;
        rdat0_nxt      = rdat0_q;
        rdat1_nxt      = rdat1_q;
        case (state)
            IDLE: begin
                if (req0 | req1) begin
                    owner_nxt      = gnt;
                    last_grant_nxt = gnt;
                    addr_nxt       = gnt ? bus.p1_addr : bus.p0_addr;
                    wdat_nxt       = gnt ? bus.p1_wr_data : bus.p0_wr_data;
                    wr_en_nxt      = gnt_wr;
                    rd_en_nxt      = ~gnt_wr;
                    is_rd_nxt      = ~gnt_wr;
                    busy_nxt[gnt]  = 1'b1;
                    state_nxt      = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.sd_ack) begin
                    wr_en_nxt      = 1'b0;
                    rd_en_nxt      = 1'b0;
                    ack_nxt[owner] = 1'b1;
                    state_nxt      = is_rd ? WAIT_RD : DRAIN;
                end
            end
            WAIT_RD: begin
                if (bus.sd_rd_ready) begin
                    if (owner) rdat1_nxt = bus.sd_rd_data;
                    else       rdat0_nxt = bus.sd_rd_data;
                    rdy_nxt[owner] = 1'b1;
                    state_nxt      = DRAIN;
                end
            end
            DRAIN: begin
                // Returning to IDLE here forces a one-cycle gap before the next grant.
                if (!bus.sd_busy) begin
                    busy_nxt  = 2'b00;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            is_rd      <= 1'b0;
            last_grant <= 1'b1;
            addr_q     <= '0;
            wdat_q     <= '0;
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            ack_q      <= 2'b00;
            rdy_q      <= 2'b00;
            busy_q     <= 2'b00;
            rdat0_q    <= '0;
            rdat1_q    <= '0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            is_rd      <= is_rd_nxt;
            last_grant <= last_grant_nxt;
            addr_q     <= addr_nxt;
            wdat_q     <= wdat_nxt;
            wr_en_q    <= wr_en_nxt;
            rd_en_q    <= rd_en_nxt;
            ack_q      <= ack_nxt;
            rdy_q      <= rdy_nxt;
            busy_q     <= busy_nxt;
            rdat0_q    <= rdat0_nxt;
            rdat1_q    <= rdat1_nxt;
        end
    end

    assign bus.sd_addr      = addr_q;
    assign bus.sd_wr_data   = wdat_q;
    assign bus.sd_wr_enable = wr_en_q;
    assign bus.sd_rd_enable = rd_en_q;
    assign bus.p0_ack       = ack_q[0];
    assign bus.p1_ack       = ack_q[1];
    assign bus.p0_rd_ready  = rdy_q[0];
    assign bus.p1_rd_ready  = rdy_q[1];
    assign bus.p0_busy      = busy_q[0];
    assign bus.p1_busy      = busy_q[1];
    assign bus.p0_rd_data   = rdat0_q;
    assign bus.p1_rd_data   = rdat1_q;
endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: queued requesters, a small controller responder, a transaction-level
// reference model compared every cycle, and literal checks per directed scenario.
module tb_sdram_arbiter;
    localparam int AW      = 25;
    localparam int DW      = 8;
    localparam int ACK_DLY = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sdram_arbiter_if #(.SD_ADDR_WIDTH(AW), .SD_DATA_WIDTH(DW)) bus ();
    sdram_arbiter #(.SD_ADDR_WIDTH(AW), .SD_DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Requesters: present queued commands as levels, drop on own ack.
    typedef struct {
        logic          wr;
        logic          rd;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } cmd_t;
    cmd_t q0[$];
    cmd_t q1[$];
    logic pres0 = 1'b0;
    logic pres1 = 1'b0;

    always @(posedge clk) begin
        cmd_t c;
        #1;
        if (rst) begin
            pres0 = 1'b0; pres1 = 1'b0;
            bus.p0_wr_enable = 1'b0; bus.p0_rd_enable = 1'b0; bus.p0_addr = '0; bus.p0_wr_data = '0;
            bus.p1_wr_enable = 1'b0; bus.p1_rd_enable = 1'b0; bus.p1_addr = '0; bus.p1_wr_data = '0;
        end else begin
            if (pres0 && bus.p0_ack) begin
                pres0 = 1'b0; bus.p0_wr_enable = 1'b0; bus.p0_rd_enable = 1'b0;
            end
            if (!pres0 && q0.size() > 0) begin
                c = q0.pop_front();
                bus.p0_wr_enable = c.wr; bus.p0_rd_enable = c.rd;
                bus.p0_addr = c.addr; bus.p0_wr_data = c.data; pres0 = 1'b1;
            end
            if (pres1 && bus.p1_ack) begin
                pres1 = 1'b0; bus.p1_wr_enable = 1'b0; bus.p1_rd_enable = 1'b0;
            end
            if (!pres1 && q1.size() > 0) begin
                c = q1.pop_front();
                bus.p1_wr_enable = c.wr; bus.p1_rd_enable = c.rd;
                bus.p1_addr = c.addr; bus.p1_wr_data = c.data; pres1 = 1'b1;
            end
        end
    end

    // Controller responder: ack after ACK_DLY cycles of enable, read data 2 cycles later, then idle.
    logic [DW-1:0] c_rdata = '0;
    logic inj_ack = 1'b0;
    logic inj_rdy = 1'b0;
    logic c_post = 1'b0;
    logic c_was_rd = 1'b0;
    int   c_cnt = 0;
    int   c_tail = 0;

    always @(posedge clk) begin
        #1;
        bus.sd_ack      = inj_ack;
        bus.sd_rd_ready = inj_rdy;
        if (inj_rdy) bus.sd_rd_data = 8'h55;
        if (rst) begin
            c_cnt = 0; c_tail = 0; c_post = 1'b0; c_was_rd = 1'b0;
            bus.sd_busy = 1'b0;
            if (!inj_rdy) bus.sd_rd_data = '0;
        end else if (bus.sd_wr_enable || bus.sd_rd_enable) begin
            bus.sd_busy = 1'b1;
            c_cnt++;
            if (c_cnt == ACK_DLY) begin
                bus.sd_ack = 1'b1; c_cnt = 0; c_tail = 0; c_post = 1'b1;
                c_was_rd = bus.sd_rd_enable;
            end
        end else if (c_post) begin
            c_tail++;
            if (c_was_rd && c_tail == 2) begin
                bus.sd_rd_ready = 1'b1; bus.sd_rd_data = c_rdata;
            end
            if (c_tail == (c_was_rd ? 3 : 2)) begin
                bus.sd_busy = 1'b0; c_post = 1'b0;
            end
        end
    end

    // Reference model: one in-flight command tracked as a record with progress flags.
    logic          m_active = 1'b0, m_owner = 1'b0, m_rd = 1'b0;
    logic          m_acked = 1'b0, m_done = 1'b0, m_last = 1'b1;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [1:0]    m_ack = 2'b00, m_rdy = 2'b00;
    logic [DW-1:0] m_rdata [2] = '{default: '0};
    int            m_grants[$];

    always @(posedge clk or posedge rst) begin
        logic r0, r1, g, w;
        if (rst) begin
            m_active = 1'b0; m_owner = 1'b0; m_rd = 1'b0; m_acked = 1'b0; m_done = 1'b0;
            m_last = 1'b1; m_addr = '0; m_wdata = '0; m_ack = 2'b00; m_rdy = 2'b00;
            m_rdata[0] = '0; m_rdata[1] = '0;
        end else begin
            m_ack = 2'b00;
            m_rdy = 2'b00;
            r0 = bus.p0_wr_enable || bus.p0_rd_enable;
            r1 = bus.p1_wr_enable || bus.p1_rd_enable;
            if (!m_active) begin
                if (r0 || r1) begin
`ifdef SDRAM_ARB_FIXED_PRIO_EN
                    g = r0 ? 1'b0 : 1'b1;
`else
                    if (r0 && r1) g = (m_last == 1'b1) ? 1'b0 : 1'b1;
                    else          g = r1;
`endif
                    w        = g ? bus.p1_wr_enable : bus.p0_wr_enable;
                    m_active = 1'b1; m_acked = 1'b0; m_done = 1'b0;
                    m_owner  = g; m_last = g; m_rd = !w;
                    m_addr   = g ? bus.p1_addr : bus.p0_addr;
                    m_wdata  = g ? bus.p1_wr_data : bus.p0_wr_data;
                    m_grants.push_back(int'(g));
                end
            end else if (!m_acked) begin
                if (bus.sd_ack) begin
                    m_acked = 1'b1; m_ack[m_owner] = 1'b1;
                end
            end else if (m_rd && !m_done) begin
                if (bus.sd_rd_ready) begin
                    m_done = 1'b1; m_rdata[m_owner] = bus.sd_rd_data; m_rdy[m_owner] = 1'b1;
                end
            end else if (!bus.sd_busy) begin
                m_active = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        logic ewr, erd;
        ewr = m_active && !m_acked && !m_rd;
        erd = m_active && !m_acked && m_rd;
        chk("sd_wr_enable", bus.sd_wr_enable, ewr);
        chk("sd_rd_enable", bus.sd_rd_enable, erd);
        if (ewr || erd) chk("sd_addr", bus.sd_addr, m_addr);
        if (ewr) chk("sd_wr_data", bus.sd_wr_data, m_wdata);
        chk("p0_busy", bus.p0_busy, m_active && !m_owner);
        chk("p1_busy", bus.p1_busy, m_active && m_owner);
        chk("p0_ack", bus.p0_ack, m_ack[0]);
        chk("p1_ack", bus.p1_ack, m_ack[1]);
        chk("p0_rd_ready", bus.p0_rd_ready, m_rdy[0]);
        chk("p1_rd_ready", bus.p1_rd_ready, m_rdy[1]);
        chk("p0_rd_data", bus.p0_rd_data, m_rdata[0]);
        chk("p1_rd_data", bus.p1_rd_data, m_rdata[1]);
    end

    // Observation counters for the literal checks.
    int cyc = 0, en_wr = 0, en_rd = 0, both_busy = 0;
    int ack_n[2] = '{0, 0};
    int rdy_n[2] = '{0, 0};
    int sdb_fall = -1, p0b_fall = -1, p1b_rise = -1;
    logic pv_sdb = 1'b0, pv_b0 = 1'b0, pv_b1 = 1'b0;
    logic [AW-1:0] cap_addr = '0;
    logic [DW-1:0] cap_data = '0;
    int dut_grants[$];

    always @(negedge clk) begin
        cyc++;
        if (bus.sd_wr_enable) begin en_wr++; cap_addr = bus.sd_addr; cap_data = bus.sd_wr_data; end
        if (bus.sd_rd_enable) begin en_rd++; cap_addr = bus.sd_addr; end
        if (bus.p0_ack) ack_n[0]++;
        if (bus.p1_ack) ack_n[1]++;
        if (bus.p0_rd_ready) rdy_n[0]++;
        if (bus.p1_rd_ready) rdy_n[1]++;
        if (bus.p0_busy && bus.p1_busy) both_busy++;
        if (pv_sdb && !bus.sd_busy) sdb_fall = cyc;
        if (pv_b0 && !bus.p0_busy) p0b_fall = cyc;
        if (!pv_b0 && bus.p0_busy) dut_grants.push_back(0);
        if (!pv_b1 && bus.p1_busy) begin p1b_rise = cyc; dut_grants.push_back(1); end
        pv_sdb = bus.sd_busy; pv_b0 = bus.p0_busy; pv_b1 = bus.p1_busy;
    end

    task automatic clr_mon();
        @(posedge clk);
        #2;
        en_wr = 0; en_rd = 0; both_busy = 0;
        ack_n = '{0, 0}; rdy_n = '{0, 0};
        sdb_fall = -1; p0b_fall = -1; p1b_rise = -1;
        dut_grants.delete(); m_grants.delete();
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 300; k++) begin
            @(negedge clk);
            if (!m_active && q0.size() == 0 && q1.size() == 0 && !pres0 && !pres1 &&
                !c_post && !bus.sd_busy) break;
        end
        chk("idle_wait_in_budget", k < 300, 1'b1);
        @(negedge clk);
    endtask

    task automatic wait_ack(input int p);
        int k;
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            if ((p == 0 && bus.p0_ack) || (p == 1 && bus.p1_ack)) break;
        end
        chk("ack_wait_in_budget", k < 100, 1'b1);
    endtask

    initial begin
        int exp_g[4];
`ifdef SDRAM_ARB_FIXED_PRIO_EN
        exp_g = '{0, 0, 0, 0};
`else
        exp_g = '{0, 1, 0, 1};
`endif
        repeat (2) @(negedge clk);
        chk("rst_p0_busy", bus.p0_busy, 1'b0);
        chk("rst_sd_wr_enable", bus.sd_wr_enable, 1'b0);
        chk("rst_p1_rd_data", bus.p1_rd_data, 8'h00);
        rst = 1'b0;

        // Single write on port 0.
        clr_mon();
        q0.push_back('{wr: 1'b1, rd: 1'b0, addr: 25'h0001234, data: 8'hA5});
        wait_idle();
        chk("t1_wr_enable_cycles", en_wr, 3);
        chk("t1_p0_ack_pulses", ack_n[0], 1);
        chk("t1_p1_ack_pulses", ack_n[1], 0);
        chk("t1_sd_addr", cap_addr, 25'h0001234);
        chk("t1_sd_wr_data", cap_data, 8'hA5);
        chk("t1_busy_fall_lag", p0b_fall - sdb_fall, 1);

        // Single read on port 1 at the top address.
        clr_mon();
        c_rdata = 8'h3C;
        q1.push_back('{wr: 1'b0, rd: 1'b1, addr: 25'h1FFFFFF, data: 8'h00});
        wait_idle();
        chk("t2_p1_rd_data", bus.p1_rd_data, 8'h3C);
        chk("t2_p1_rd_ready_pulses", rdy_n[1], 1);
        chk("t2_p0_rd_ready_pulses", rdy_n[0], 0);
        chk("t2_p0_rd_data", bus.p0_rd_data, 8'h00);
        chk("t2_rd_enable_cycles", en_rd, 3);
        chk("t2_sd_addr", cap_addr, 25'h1FFFFFF);

        // Both ports request continuously.
        clr_mon();
        c_rdata = 8'h5A;
        for (int i = 0; i < 4; i++) begin
            q0.push_back('{wr: 1'b1, rd: 1'b0, addr: AW'(32'h100 + i), data: DW'(i)});
            q1.push_back('{wr: 1'b0, rd: 1'b1, addr: AW'(32'h200 + i), data: 8'h00});
        end
        wait_idle();
        chk("t3_grant_count", dut_grants.size(), 8);
        for (int i = 0; i < 4; i++) begin
            chk("t3_dut_grant", (dut_grants.size() > i) ? dut_grants[i] : -1, exp_g[i]);
            chk("t3_model_grant", (m_grants.size() > i) ? m_grants[i] : -1, exp_g[i]);
        end

        // Port 1 requests while port 0 drains.
        clr_mon();
        q0.push_back('{wr: 1'b1, rd: 1'b0, addr: 25'h00ABCDE, data: 8'h11});
        wait_ack(0);
        q1.push_back('{wr: 1'b1, rd: 1'b0, addr: 25'h0000777, data: 8'h22});
        wait_idle();
        chk("t4_grant_gap", p1b_rise - p0b_fall, 1);
        chk("t4_busy_overlap", both_busy, 0);

        // Write and read enables together.
        clr_mon();
        q0.push_back('{wr: 1'b1, rd: 1'b1, addr: 25'h0000042, data: 8'h99});
        wait_idle();
        chk("t5_wr_enable_cycles", en_wr, 3);
        chk("t5_rd_enable_cycles", en_rd, 0);
        chk("t5_p0_rd_ready_pulses", rdy_n[0], 0);
        chk("t5_p0_ack_pulses", ack_n[0], 1);

        // Reset while waiting for read data.
        clr_mon();
        c_rdata = 8'h77;
        q1.push_back('{wr: 1'b0, rd: 1'b1, addr: 25'h0001000, data: 8'h00});
        wait_ack(1);
        #2 rst = 1'b1;
        #1;
        chk("t6_async_p1_busy", bus.p1_busy, 1'b0);
        chk("t6_async_p1_ack", bus.p1_ack, 1'b0);
        chk("t6_async_p1_rd_data", bus.p1_rd_data, 8'h00);
        chk("t6_async_sd_enables", {bus.sd_wr_enable, bus.sd_rd_enable}, 2'b00);
        chk("t6_async_sd_addr", bus.sd_addr, 25'h0000000);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        clr_mon();
        @(negedge clk);
        inj_ack = 1'b1; inj_rdy = 1'b1;
        @(negedge clk);
        inj_ack = 1'b0; inj_rdy = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_stray_rd_ready", rdy_n[0] + rdy_n[1], 0);
        chk("t6_stray_ack", ack_n[0] + ack_n[1], 0);
        clr_mon();
        c_rdata = 8'hC3;
        q1.push_back('{wr: 1'b0, rd: 1'b1, addr: 25'h0002000, data: 8'h00});
        wait_idle();
        chk("t6_next_rd_data", bus.p1_rd_data, 8'hC3);
        chk("t6_next_rd_ready", rdy_n[1], 1);
        chk("t6_next_ack", ack_n[1], 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run still active at t=%0t, limit 100000", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
